// File: rtl/sdram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the two-client SDRAM arbiter:
//   - default ADDR_W / DATA_W / TIMEOUT values
//   - FSM state encoding (IDLE, BUSY, DONE)
//   - client selection helper (round-robin between two requesters)
// ----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 22;
    localparam int unsigned DATA_W_DEF  = 128;
    localparam int unsigned TIMEOUT_DEF = 4096;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle = 2'd0;
    localparam arb_state_t StBusy = 2'd1;
    localparam arb_state_t StDone = 2'd2;

    // Returns the index of the client to grant. With both requesting, the
    // client that was not served last wins.
    function automatic logic pick_client(input logic req0, input logic req1,
                                         input logic last_gnt);
        if (req0 && req1) begin
            return ~last_gnt;
        end
        return req1 & ~req0;
    endfunction

endpackage

// File: rtl/sdram_arb_timer.sv
// ----------------------------------------------------------------------------
// sdram_arb_timer
// Clearable, enabled cycle counter used to bound the wait for a controller
// acknowledge. The counter saturates at TIMEOUT-1 and flags expiry there.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     synchronous active-low reset
//   clr_i      return the count to zero (has priority over en_i)
//   en_i       advance the count by one this cycle
//   expired_o  count has reached TIMEOUT-1
// ----------------------------------------------------------------------------
module sdram_arb_timer #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] count_q, count_d;

    assign expired_o = (count_q == LastCnt);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// ----------------------------------------------------------------------------
// sdram_arbiter
// Two-client arbiter in front of a single SDRAM controller port. One transfer
// is in flight at a time; a client is latched in IDLE, its request is held to
// the controller in BUSY until the matching ack (or a timeout), and the
// client's ack/err pulse is presented in DONE. All outputs are registered.
//
// Ports:
//   MAX10_CLK1_50              clock, rising edge
//   ireset_n                   synchronous active-low reset
//   cN_req/we/addr/wdata       client N request (held until its ack)
//   cN_ack/err/rdata           client N completion pulse, timeout flag, read data
//   mem_write_req/read_req     request strobes to the controller
//   mem_address/write_data     latched transfer address and write data
//   mem_write_ack/read_ack     controller acknowledges
//   mem_read_data              controller read data
//   busy                       arbiter not idle
//   grant                      index of the client owning the controller
// ----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              MAX10_CLK1_50,
    input  logic              ireset_n,

    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic              c0_err,
    output logic [DATA_W-1:0] c0_rdata,

    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic              c1_err,
    output logic [DATA_W-1:0] c1_rdata,

    output logic              mem_write_req,
    output logic              mem_read_req,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_write_ack,
    input  logic              mem_read_ack,
    input  logic [DATA_W-1:0] mem_read_data,

    output logic              busy,
    output logic              grant
);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;

    logic              sel;
    logic              ack_match;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expired;

    assign tmr_clr = (state_q != StBusy);
    assign tmr_en  = (state_q == StBusy);

    sdram_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (MAX10_CLK1_50),
        .rst_ni    (ireset_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_req_d   = 1'b0;
        rd_req_d   = 1'b0;
        ack_d      = '0;
        err_d      = '0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        sel        = 1'b0;
        // Only the ack matching the latched direction can complete a transfer.
        ack_match  = we_q ? mem_write_ack : mem_read_ack;

        case (state_q)
            StIdle: begin
                if (c0_req || c1_req) begin
                    sel     = pick_client(c0_req, c1_req, last_gnt_q);
                    grant_d = sel;
                    we_d    = sel ? c1_we    : c0_we;
                    addr_d  = sel ? c1_addr  : c0_addr;
                    wdata_d = sel ? c1_wdata : c0_wdata;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // An ack only counts once our request is visible to the
                // controller; ack wins over a simultaneous timer expiry.
                if ((wr_req_q || rd_req_q) && ack_match) begin
                    if (!we_q) begin
                        if (grant_q) begin
                            rdata1_d = mem_read_data;
                        end else begin
                            rdata0_d = mem_read_data;
                        end
                    end
                    ack_d[grant_q] = 1'b1;
                    state_d        = StDone;
                end else if (tmr_expired) begin
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    state_d        = StDone;
                end else begin
                    wr_req_d = we_q;
                    rd_req_d = ~we_q;
                end
            end
            StDone: begin
                last_gnt_d = grant_q;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!ireset_n) begin
            state_q    <= StIdle;
            grant_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_req_q   <= wr_req_d;
            rd_req_q   <= rd_req_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign c0_ack         = ack_q[0];
    assign c1_ack         = ack_q[1];
    assign c0_err         = err_q[0];
    assign c1_err         = err_q[1];
    assign c0_rdata       = rdata0_q;
    assign c1_rdata       = rdata1_q;
    assign mem_write_req  = wr_req_q;
    assign mem_read_req   = rd_req_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign busy           = busy_q;
    assign grant          = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter with TIMEOUT = 16. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
// ----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 128;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          ireset_n;
    logic          c0_req, c0_we, c1_req, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_ack, c0_err, c1_ack, c1_err;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          mem_write_req, mem_read_req;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_ack, mem_read_ack;
    logic [DW-1:0] mem_read_data;
    logic          busy, grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .MAX10_CLK1_50  (clk),
        .ireset_n       (ireset_n),
        .c0_req         (c0_req),
        .c0_we          (c0_we),
        .c0_addr        (c0_addr),
        .c0_wdata       (c0_wdata),
        .c0_ack         (c0_ack),
        .c0_err         (c0_err),
        .c0_rdata       (c0_rdata),
        .c1_req         (c1_req),
        .c1_we          (c1_we),
        .c1_addr        (c1_addr),
        .c1_wdata       (c1_wdata),
        .c1_ack         (c1_ack),
        .c1_err         (c1_err),
        .c1_rdata       (c1_rdata),
        .mem_write_req  (mem_write_req),
        .mem_read_req   (mem_read_req),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_ack  (mem_write_ack),
        .mem_read_ack   (mem_read_ack),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .grant          (grant)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a mem request, checks the owner, acks it and checks
    // the one-cycle client completion pulse.
    task automatic serve(input string tag, input logic exp_g, input logic exp_we,
                         input logic [DW-1:0] rd);
        int n;
        n = 0;
        while (!(mem_write_req || mem_read_req) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_wait"}, DW'(n < 20), DW'(1));
        chk({tag, "_grant"}, DW'(grant), DW'(exp_g));
        chk({tag, "_dir"}, DW'(mem_write_req), DW'(exp_we));
        if (exp_we) begin
            mem_write_ack = 1'b1;
        end else begin
            mem_read_ack  = 1'b1;
            mem_read_data = rd;
        end
        tick();
        mem_write_ack = 1'b0;
        mem_read_ack  = 1'b0;
        mem_read_data = DW'(128'hbad0_bad0);
        chk({tag, "_ack"}, DW'(exp_g ? c1_ack : c0_ack), DW'(1));
        chk({tag, "_other_ack"}, DW'(exp_g ? c0_ack : c1_ack), DW'(0));
        chk({tag, "_err"}, DW'(exp_g ? c1_err : c0_err), DW'(0));
        if (!exp_we && exp_g) begin
            chk({tag, "_rdata"}, c1_rdata, rd);
        end
        tick();
        chk({tag, "_pulse"}, DW'(c0_ack | c1_ack), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_hi, n_busy;

        ireset_n      = 1'b0;
        c0_req        = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_req        = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        mem_write_ack = 1'b0; mem_read_ack = 1'b0; mem_read_data = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_grant", DW'(grant), DW'(0));
        chk("rst_acks", DW'({c0_ack, c1_ack, c0_err, c1_err}), DW'(0));
        chk("rst_memreq", DW'({mem_write_req, mem_read_req}), DW'(0));
        chk("rst_rdata0", c0_rdata, DW'(0));
        chk("rst_rdata1", c1_rdata, DW'(0));
        ireset_n = 1'b1;
        tick();

        // c0 write, addr 1, ack after five request cycles
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = AW'(1); c0_wdata = DW'(128'h3c4d5e6f);
        tick();
        chk("wr_busy", DW'(busy), DW'(1));
        chk("wr_grant", DW'(grant), DW'(0));
        chk("wr_latency", DW'(mem_write_req), DW'(0));
        tick();
        chk("wr_req", DW'(mem_write_req), DW'(1));
        chk("wr_no_rd", DW'(mem_read_req), DW'(0));
        chk("wr_addr", DW'(mem_address), DW'(1));
        chk("wr_data", mem_write_data, DW'(128'h3c4d5e6f));
        n_hi = mem_write_req ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_write_req === 1'b1) n_hi++;
        end
        mem_write_ack = 1'b1;
        tick();
        mem_write_ack = 1'b0;
        chk("wr_hi_cycles", DW'(n_hi), DW'(5));
        chk("wr_req_drop", DW'(mem_write_req), DW'(0));
        chk("wr_c0_ack", DW'(c0_ack), DW'(1));
        chk("wr_c0_err", DW'(c0_err), DW'(0));
        chk("wr_c1_ack", DW'(c1_ack), DW'(0));
        c0_req = 1'b0;
        tick();
        chk("wr_ack_pulse", DW'(c0_ack), DW'(0));
        chk("wr_idle", DW'(busy), DW'(0));

        // c1 read, addr 1
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = AW'(1);
        tick();
        chk("rd_grant", DW'(grant), DW'(1));
        tick();
        chk("rd_req", DW'(mem_read_req), DW'(1));
        chk("rd_no_wr", DW'(mem_write_req), DW'(0));
        chk("rd_addr", DW'(mem_address), DW'(1));
        mem_read_ack = 1'b1; mem_read_data = DW'(128'h3c4d5e6f);
        tick();
        mem_read_ack = 1'b0; mem_read_data = DW'(128'hdead);
        chk("rd_c1_ack", DW'(c1_ack), DW'(1));
        chk("rd_c1_err", DW'(c1_err), DW'(0));
        chk("rd_c0_ack", DW'(c0_ack), DW'(0));
        chk("rd_rdata", c1_rdata, DW'(128'h3c4d5e6f));
        c1_req = 1'b0;
        tick();
        tick();
        chk("rd_ack_pulse", DW'(c1_ack), DW'(0));
        chk("rd_rdata_held", c1_rdata, DW'(128'h3c4d5e6f));
        chk("rd_c0_rdata", c0_rdata, DW'(0));

        // Both clients request continuously: round-robin 0,1,0,1
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = AW'(2); c0_wdata = DW'(128'haaaa);
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = AW'(3);
        serve("rr0", 1'b0, 1'b1, '0);
        serve("rr1", 1'b1, 1'b0, DW'(128'h1111));
        serve("rr2", 1'b0, 1'b1, '0);
        serve("rr3", 1'b1, 1'b0, DW'(128'h2222));
        c0_req = 1'b0; c1_req = 1'b0;
        tick();
        tick();
        chk("rr_idle", DW'(busy), DW'(0));
        chk("rr_c0_rdata", c0_rdata, DW'(0));

        // Timeout: c0 read with no ack
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = AW'(5);
        mem_read_data = DW'(128'hbad);
        tick();
        n = 0; n_busy = 0; n_hi = 0;
        while (c0_ack !== 1'b1 && n < 40) begin
            if (busy === 1'b1) n_busy++;
            if (mem_read_req === 1'b1) n_hi++;
            tick();
            n++;
        end
        chk("to_wait", DW'(n < 40), DW'(1));
        chk("to_busy_cycles", DW'(n_busy), DW'(16));
        chk("to_req_cycles", DW'(n_hi), DW'(15));
        chk("to_err", DW'(c0_err), DW'(1));
        chk("to_req_drop", DW'(mem_read_req), DW'(0));
        chk("to_rdata", c0_rdata, DW'(0));
        c0_req = 1'b0;
        tick();
        // Next request after a timeout is serviced normally
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = AW'(6);
        serve("after_to", 1'b1, 1'b0, DW'(128'h55));
        c1_req = 1'b0;
        tick();

        // Stray read ack during a write, then write ack on the expiry cycle
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = AW'(7); c0_wdata = DW'(128'h77);
        tick();
        tick();
        chk("stray_req", DW'(mem_write_req), DW'(1));
        mem_read_ack = 1'b1;
        tick();
        tick();
        chk("stray_ignored", DW'(mem_write_req), DW'(1));
        chk("stray_no_ack", DW'(c0_ack), DW'(0));
        mem_read_ack = 1'b0;
        repeat (12) tick();
        chk("exp_req_held", DW'(mem_write_req), DW'(1));
        mem_write_ack = 1'b1;
        tick();
        mem_write_ack = 1'b0;
        chk("exp_ack", DW'(c0_ack), DW'(1));
        chk("exp_err", DW'(c0_err), DW'(0));
        c0_req = 1'b0;
        tick();

        // Reset in BUSY aborts the transfer
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = AW'(9);
        tick();
        tick();
        chk("rb_req", DW'(mem_read_req), DW'(1));
        ireset_n = 1'b0;
        tick();
        chk("rb_memreq", DW'({mem_write_req, mem_read_req}), DW'(0));
        chk("rb_busy", DW'(busy), DW'(0));
        chk("rb_ack", DW'(c1_ack), DW'(0));
        chk("rb_grant", DW'(grant), DW'(0));
        ireset_n = 1'b1;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = AW'(10); c0_wdata = DW'(128'h1234);
        tick();
        chk("rb_first_busy", DW'(busy), DW'(1));
        chk("rb_first_grant", DW'(grant), DW'(0));
        tick();
        chk("rb_first_req", DW'(mem_write_req), DW'(1));
        chk("rb_first_addr", DW'(mem_address), DW'(10));
        mem_write_ack = 1'b1;
        tick();
        mem_write_ack = 1'b0;
        chk("rb_c0_ack", DW'(c0_ack), DW'(1));
        chk("rb_c1_ack", DW'(c1_ack), DW'(0));
        c0_req = 1'b0;
        serve("rb_c1", 1'b1, 1'b0, DW'(128'h99));
        c1_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
